// File: rtl/alu_issue_queue_if.sv
// Command handshake between an upstream issuer, the issue queue and the arithmetic unit.
// The master side issues commands and consumes results; the slave side is the queue.
interface alu_issue_queue_if #(
    parameter int N = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic [2:0]   in_op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [2:0]   instruction;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, a, b, instruction, out_valid
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, a, b, instruction, out_valid
    );
endinterface

// File: rtl/alu_issue_queue.sv
// Issue queue: DEPTH-entry circular FIFO plus one output register feeding the arithmetic unit.
// Latency: a command accepted into an empty queue is presented one edge later (no bypass).
// Backpressure: in_ready = (level < DEPTH) from registered state; output register stalls on !out_ready.
module alu_issue_queue #(
    parameter int N     = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     clr_err,
    alu_issue_queue_if.slave         bus,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     err
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    typedef struct packed {
        logic [2:0]   op;
        logic [N-1:0] a;
        logic [N-1:0] b;
    } cmd_t;

    cmd_t          mem [DEPTH];
    cmd_t          in_cmd;
    cmd_t          head_cmd;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          out_vld_q;
    logic          accept;
    logic          legal;
    logic          push;
    logic          pop;

    assign in_cmd   = '{op: bus.in_op, a: bus.in_a, b: bus.in_b};
    assign head_cmd = mem[rd_ptr];

    // Opcodes 010 and 011 have no arithmetic-unit encoding; such commands are dropped and flagged.
    assign legal  = (bus.in_op != 3'b010) && (bus.in_op != 3'b011);
    assign accept = bus.in_valid && bus.in_ready && !flush;
    assign push   = accept && legal;
    assign pop    = (level != '0) && (!out_vld_q || bus.out_ready) && !flush;

    assign bus.in_ready  = (level < FULL_LVL);
    assign bus.out_valid = out_vld_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_cmd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // Full/empty are tracked by level; pointer equality is ambiguous.
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push) begin
                level <= level - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q       <= 1'b0;
            bus.a           <= '0;
            bus.b           <= '0;
            bus.instruction <= 3'b000;
        end else if (flush) begin
            out_vld_q <= 1'b0;
        end else if (pop) begin
            out_vld_q       <= 1'b1;
            bus.a           <= head_cmd.a;
            bus.b           <= head_cmd.b;
            bus.instruction <= head_cmd.op;
        end else if (bus.out_ready) begin
            out_vld_q <= 1'b0;
        end
    end

    // A new illegal accept wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (accept && !legal) begin
            err <= 1'b1;
        end else if (clr_err) begin
            err <= 1'b0;
        end
    end
endmodule

// File: doc/alu_issue_queue.md
ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

Interface
REQ-001 Parameter N, default 4: operand width in bits.
REQ-002 Parameter DEPTH, default 4: FIFO entries; power of two, >= 2.
REQ-003 Port clk, input, 1: single clock, rising edge active.
REQ-004 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port in_valid, input, 1: upstream command valid.
REQ-006 Port in_ready, output, 1: queue can accept a command this cycle.
REQ-007 Port in_a, input, N: operand A of the command.
REQ-008 Port in_b, input, N: operand B of the command.
REQ-009 Port in_op, input, 3: opcode of the command, in the arithmetic unit's encoding.
REQ-010 Port flush, input, 1: synchronous discard of all queued and presented commands.
REQ-011 Port clr_err, input, 1: synchronous clear of the err flag.
REQ-012 Port a, output, N: operand A presented to the arithmetic unit.
REQ-013 Port b, output, N: operand B presented to the arithmetic unit.
REQ-014 Port instruction, output, 3: opcode presented to the arithmetic unit.
REQ-015 Port out_valid, output, 1: a, b and instruction hold a valid command.
REQ-016 Port out_ready, input, 1: the consumer takes the presented command this cycle.
REQ-017 Port level, output, $clog2(DEPTH)+1: number of occupied FIFO entries; excludes the output register.
REQ-018 Port err, output, 1: sticky flag, set when an illegal opcode is dropped.

Function
REQ-019 Storage SHALL be a circular FIFO of DEPTH entries {in_op, in_a, in_b} followed by one output register driving a, b and instruction; total capacity is DEPTH+1 commands.
REQ-020 in_ready SHALL equal (level < DEPTH), decoded from registered state only, with no combinational path from out_ready or in_valid.
REQ-021 Accept event: in_valid && in_ready && !flush at a rising edge.
REQ-022 On an accept with a legal in_op (000, 001, 100, 101, 110, 111), the entry SHALL be written at the write pointer, and the write pointer SHALL advance modulo DEPTH.
REQ-023 On an accept with illegal in_op (010, 011):
- handshake completes;
- no entry is written;
- err = 1 after that edge.
REQ-024 err SHALL stay 1 until an edge with clr_err = 1 and no new illegal accept; a simultaneous illegal accept and clr_err SHALL leave err = 1.
REQ-025 The output register SHALL load the FIFO head when level > 0 and (!out_valid || out_ready); the read pointer advances modulo DEPTH and out_valid = 1.
REQ-026 When out_valid && out_ready and level == 0, out_valid SHALL go 0; a, b and instruction SHALL hold their last values.
REQ-027 While out_valid && !out_ready, a, b and instruction SHALL remain stable.
REQ-028 Latency: a legal command accepted at edge k into an empty queue SHALL have out_valid = 1 after edge k+1; there is no bypass path.
REQ-029 At one edge, a push and a pop SHALL leave level unchanged and keep both pointers consistent, including when level == DEPTH-1.
REQ-030 Order of presentation SHALL equal order of legal acceptance; no reorder, duplication or loss except by flush.
REQ-031 flush = 1 SHALL, at that edge:
- set level = 0;
- set both pointers to 0;
- set out_valid = 0;
- block any accept.
err SHALL be unaffected; a, b and instruction SHALL hold their values.
REQ-032 Pointer wrap: after DEPTH writes, the write pointer returns to 0; full and empty SHALL be distinguished by level, never by pointer equality alone.

Reset
REQ-033 While rst_n = 0, regardless of clk, the block SHALL force:
- level = 0 and both pointers = 0;
- out_valid = 0 and err = 0;
- a = b = 0 and instruction = 000;
- in_ready = 1 once level = 0.
REQ-034 Reset asserted mid-operation SHALL discard all queued commands; the first accept after rst_n rises SHALL behave as into an empty queue.

Verification
REQ-035 Single command: N=4, accept {op=000, a=3, b=5} at edge 1 with out_ready = 1 -> out_valid = 1 after edge 2 with a=3, b=5, instruction=000; out_valid = 0 after edge 3.
REQ-036 Fill and backpressure: out_ready = 0, offer 6 legal commands on consecutive cycles -> 5 accepted, level = 4, in_ready = 0; then out_ready = 1 -> all 5 emerge in order.
REQ-037 Illegal opcode: accept op=010, then op=001 (a=9, b=2) -> err = 1, level peaks at 1, and only op=001 is presented; clr_err pulse -> err = 0.
REQ-038 Simultaneous push and pop: with level = 3 and out_valid = 1, assert in_valid and out_ready for 10 cycles -> level stays 3, pointers wrap, and the sequence is unbroken.
REQ-039 Flush while full: level = 4, out_valid = 1, flush = 1 with in_valid = 1 -> next cycle level = 0, out_valid = 0, nothing accepted, err unchanged.
REQ-040 Async reset: drop rst_n between clock edges with level = 2 -> out_valid, level and err read 0 immediately, and in_ready = 1.
